// File: rtl/sdpb_burst_reader.sv
// -----------------------------------------------------------------------------
// sdpb_burst_reader
//   Read-side master for the sonar scan-buffer block RAM (port B). On start it
//   reads `len` consecutive bytes from `base`. The address wraps at the top of
//   the RAM. The bytes go out as a valid/ready stream, and m_last marks the
//   final byte. The RAM's 1-clock read latency is hidden behind a 2-entry skid
//   FIFO. Reads are issued only when a FIFO slot is guaranteed for the data, so
//   back-pressure never drops or duplicates a byte.
//
// Ports
//   clk, resetn         system clock (also RAM clkb), async active-low reset
//   start, base, len    burst request; sampled only in IDLE
//   busy, done          burst in progress / 1-clk completion pulse
//   adb, ceb, oce,      RAM port B: read address, read enable,
//   resetb, ram_dout    output enable (1), port reset (0), read data
//   m_data, m_valid,    byte stream towards the scan-line/UART consumer
//   m_last, m_ready
// -----------------------------------------------------------------------------
module sdpb_burst_reader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] adb,
    output logic              ceb,
    output logic              oce,
    output logic              resetb,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remain;
    logic              inflight;       // a read was issued last edge; data on ram_dout now
    logic              inflight_last;  // ...and it was the final byte of the burst

    logic [1:0][DATA_W-1:0] fifo_data;
    logic [1:0]             fifo_last;
    logic                   wr_ptr, rd_ptr;
    logic [1:0]             occ;

    logic       pop, issue, last_issue;
    logic [1:0] pending;

    assign pop = m_valid & m_ready;

    // Bytes that will still hold a FIFO slot after this edge: the ones stored now,
    // plus the one arriving from the RAM, minus the one leaving. A new read is
    // issued only if its byte will have a free slot when it lands.
    assign pending    = occ + {1'b0, inflight} - {1'b0, pop};
    assign issue      = (state == READ) && (pending < 2'd2);
    assign last_issue = issue && (remain == (ADDR_W+1)'(1));

    assign ceb    = issue;
    assign adb    = addr;
    assign oce    = 1'b1;
    assign resetb = 1'b0;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    assign m_valid = (occ != 2'd0);
    assign m_data  = fifo_data[rd_ptr];
    assign m_last  = m_valid & fifo_last[rd_ptr];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (len == '0) ? DONE : READ;
            READ:  if (last_issue) state_nxt = DRAIN;
            // The last byte is the last one pushed. When it handshakes, the FIFO
            // empties and nothing is in flight, so go straight to DONE on that edge.
            DRAIN: if (pop && m_last) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- address / count / in-flight tracking ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr          <= '0;
            remain        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            if (state == IDLE && start && len != '0) begin
                addr   <= base;
                remain <= len;
            end else if (issue) begin
                addr   <= addr + 1'b1;        // natural wrap at 2**ADDR_W
                remain <= remain - 1'b1;
            end
            inflight      <= issue;
            inflight_last <= last_issue;
        end
    end

    // ---------------- 2-entry skid FIFO ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fifo_data <= '0;
            fifo_last <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ       <= 2'd0;
        end else begin
            if (inflight) begin
                fifo_data[wr_ptr] <= ram_dout;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= pending;
        end
    end

endmodule

// File: tb/tb_sdpb_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_sdpb_burst_reader
//   Directed bench for sdpb_burst_reader. It contains a behavioural model of the
//   2048x8 RAM read port. All stimulus is driven at the falling edge, and the
//   outputs are observed 1 time unit later. Cycle index k counts rising edges
//   after the edge that samples start (k=0 is the first observation).
// -----------------------------------------------------------------------------
module tb_sdpb_burst_reader;
    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] ram_dout = '0;
    logic          busy, done, ceb, oce, resetb, m_valid, m_last;
    logic [AW-1:0] adb;
    logic [DW-1:0] m_data;

    sdpb_burst_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .base(base), .len(len),
        .busy(busy), .done(done), .adb(adb), .ceb(ceb), .oce(oce),
        .resetb(resetb), .ram_dout(ram_dout), .m_data(m_data),
        .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // RAM port B model: registered read when ceb is high, data held otherwise.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) if (ceb) ram_dout <= ram[adb];

    int n_cmp = 0, n_err = 0;
    int cyc_cnt, ready_mode;
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    int            got_k[$];
    logic [AW-1:0] iss_a[$];
    int done_k, done_cnt, issued, max_out, stall_bad, valid_seen, ceb_seen, busy_seen;
    logic prev_stall;
    logic [DW-1:0] prev_d;
    logic prev_l;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        got_d.delete(); got_l.delete(); got_k.delete(); iss_a.delete();
        done_k = -1; done_cnt = 0; issued = 0; max_out = 0; stall_bad = 0;
        valid_seen = 0; ceb_seen = 0; busy_seen = 0; prev_stall = 1'b0;
    endtask

    // One clock: set m_ready at the falling edge, then observe.
    task automatic cyc();
        @(negedge clk);
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        cyc_cnt++;
        if (prev_stall && (!m_valid || m_data !== prev_d || m_last !== prev_l)) stall_bad++;
        prev_stall = m_valid && !m_ready;
        prev_d = m_data;
        prev_l = m_last;
        if (m_valid) valid_seen++;
        if (busy) busy_seen++;
        if (m_valid && m_ready) begin
            got_d.push_back(m_data); got_l.push_back(m_last); got_k.push_back(cyc_cnt);
        end
        if (ceb) begin
            ceb_seen++; issued++; iss_a.push_back(adb);
        end
        if (issued - got_d.size() > max_out) max_out = issued - got_d.size();
        if (done) begin
            done_cnt++;
            if (done_k < 0) done_k = cyc_cnt;
        end
    endtask

    // Launch a burst and clock until done, the budget runs out, or abort_n bytes
    // have been accepted. poke_k >= 0 injects a stray start pulse after cycle poke_k.
    task automatic run(input logic [AW-1:0] b, input int l, input int mode,
                       input int budget, input int poke_k, input int abort_n);
        clear_obs();
        ready_mode = mode;
        start = 1'b1; base = b; len = (AW+1)'(l);
        cyc_cnt = -1;
        cyc();
        start = 1'b0;
        while (done_k < 0 && cyc_cnt < budget && !(abort_n > 0 && got_d.size() >= abort_n)) begin
            if (cyc_cnt == poke_k) begin
                start = 1'b1; base = 11'h555; len = 12'd5;
            end
            cyc();
            start = 1'b0;
        end
    endtask

    task automatic check_stream(input string tag, input logic [AW-1:0] b, input int l);
        int bad_d = 0, bad_l = 0;
        check({tag, "_count"}, got_d.size(), l);
        for (int i = 0; i < got_d.size() && i < l; i++) begin
            if (got_d[i] !== ram[(int'(b) + i) % DEPTH]) bad_d++;
            if (got_l[i] !== (i == l - 1)) bad_l++;
        end
        check({tag, "_data_errs"}, bad_d, 0);
        check({tag, "_last_errs"}, bad_l, 0);
    endtask

    function automatic logic [DW-1:0] gd(input int i);
        return (i < got_d.size()) ? got_d[i] : 8'hxx;
    endfunction

    function automatic int gk(input int i);
        return (i >= 0 && i < got_k.size()) ? got_k[i] : -1;
    endfunction

    function automatic logic [AW-1:0] ga(input int i);
        return (i < iss_a.size()) ? iss_a[i] : 11'hxxx;
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i * 37 + (i >> 8) * 101 + 3);
        ram[16'h010] = 8'hA0; ram[16'h011] = 8'hA1; ram[16'h012] = 8'hA2; ram[16'h013] = 8'hA3;
        ready_mode = 1;
        clear_obs();
        cyc_cnt = 0;

        // Reset state
        cyc(); cyc();
        check("rst_busy", busy, 0);     check("rst_done", done, 0);
        check("rst_ceb", ceb, 0);       check("rst_adb", adb, 0);
        check("rst_valid", m_valid, 0); check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);
        check("oce_const", oce, 1);     check("resetb_const", resetb, 0);
        resetn = 1'b1;
        cyc();

        // T1: basic 4-byte burst, consumer always ready
        run(11'h010, 4, 1, 40, -1, 0);
        check("t1_b0", gd(0), 8'hA0); check("t1_b1", gd(1), 8'hA1);
        check("t1_b2", gd(2), 8'hA2); check("t1_b3", gd(3), 8'hA3);
        check_stream("t1", 11'h010, 4);
        check("t1_first_k", gk(0), 2);
        check("t1_last_k", gk(3), 5);
        check("t1_done_k", done_k, 6);
        cyc();
        check("t1_busy_after", busy, 0);
        check("t1_done_cnt", done_cnt, 1);

        // T2: wrap across the top of the RAM
        cyc();
        run(11'h7FE, 4, 1, 40, -1, 0);
        check("t2_a0", ga(0), 11'h7FE); check("t2_a1", ga(1), 11'h7FF);
        check("t2_a2", ga(2), 11'h000); check("t2_a3", ga(3), 11'h001);
        check_stream("t2", 11'h7FE, 4);
        check("t2_done_k", done_k, 6);
        cyc();

        // T3: random back-pressure
        run(11'h200, 16, 2, 400, -1, 0);
        check("t3_done_seen", done_k >= 0, 1);
        check_stream("t3", 11'h200, 16);
        check("t3_max_outstanding_ok", max_out <= 2, 1);
        check("t3_stall_hold_errs", stall_bad, 0);
        check("t3_reads_issued", issued, 16);
        cyc();

        // T4a: zero-length request
        run(11'h050, 0, 1, 10, -1, 0);
        check("t4_len0_done_k", done_k, 0);
        check("t4_len0_ceb", ceb_seen, 0);
        check("t4_len0_valid", valid_seen, 0);
        cyc();
        check("t4_len0_busy_after", busy, 0);

        // T4b: a start pulse during an active burst is ignored
        cyc();
        run(11'h080, 8, 1, 100, 3, 0);
        check_stream("t4_busy_start", 11'h080, 8);
        check("t4_done_cnt", done_cnt, 1);
        clear_obs();
        for (int i = 0; i < 6; i++) cyc();
        check("t4_no_requeue_busy", busy_seen, 0);
        check("t4_no_requeue_ceb", ceb_seen, 0);

        // T5: reset asserted mid-burst
        run(11'h100, 8, 1, 100, -1, 3);
        check("t5_got3", got_d.size() >= 3, 1);
        cyc();
        done_cnt = 0;
        resetn = 1'b0;
        #1;
        check("t5_busy", busy, 0);     check("t5_done", done, 0);
        check("t5_ceb", ceb, 0);       check("t5_adb", adb, 0);
        check("t5_valid", m_valid, 0); check("t5_last", m_last, 0);
        check("t5_data", m_data, 0);
        cyc(); cyc();
        check("t5_no_done", done_cnt, 0);
        resetn = 1'b1;
        cyc();
        run(11'h000, 2, 1, 40, -1, 0);
        check_stream("t5_after", 11'h000, 2);
        check("t5_after_done_k", done_k, 4);
        cyc();

        // T6: full-RAM burst from the middle, wrapping once
        run(11'h400, 2048, 1, 2100, -1, 0);
        check_stream("t6", 11'h400, 2048);
        check("t6_first_k", gk(0), 2);
        check("t6_last_k", gk(2047), 2049);
        check("t6_last_byte", gd(2047), ram[16'h3FF]);
        check("t6_done_k", done_k, 2050);
        cyc();
        check("t6_busy_after", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
